pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle control FSM for the picoMIPS core. It fetches each instruction, decodes the opcode, and drives the program counter's increment, relative-branch and absolute-branch strobes. It also sequences the datapath side effects: register writeback, the multi-cycle multiplier handshake, and the wait on the user input button. The block sits between instruction memory (opcode in) and the program counter, register file and multiplier (control strobes out).

## Interface
Parameters:
- OPCODE_WIDTH, 4, width of opcode field
- RETIRE_WIDTH, 16, width of retired-instruction counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- run  in  1  level; FETCH advances only while 1
- opcode  in  OPCODE_WIDTH  opcode field of current instruction memory output
- zero_flag  in  1  ALU zero flag, registered in datapath
- mul_done  in  1  one-cycle pulse from multiplier, result valid
- btn  in  1  synchronised user input button, active-high
- ir_load  out  1  load instruction register
- PC_incr  out  1  PC += 1
- PC_rel_branch  out  1  PC += branch offset
- PC_abs_branch  out  1  PC = branch address
- wb_en  out  1  register-file write enable
- mul_start  out  1  one-cycle multiplier start pulse
- in_sel  out  1  writeback source is input switches
- halted  out  1  core stopped
- illegal  out  1  one-cycle pulse, undefined opcode decoded
- retired_count  out  RETIRE_WIDTH  instructions completed

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 ADDI, 3 MUL, 4 BEQ, 5 BNE, 6 JMP, 7 IN, 8 HALT. Values 9-15 are illegal and execute as NOP with an `illegal` pulse.
- States: FETCH, EXEC, MULWAIT, INPRESS, INRELEASE, HALT.
- FETCH: if run=1, assert ir_load and go to EXEC; otherwise stay, with all strobes 0.
- EXEC (opcode from IR):
  - NOP/illegal: PC_incr; go to FETCH.
  - ADD/ADDI: wb_en + PC_incr; go to FETCH.
  - MUL: mul_start; go to MULWAIT.
  - BEQ: zero_flag=1 gives PC_rel_branch, else PC_incr. BNE is the inverse. Go to FETCH.
  - JMP: PC_abs_branch; go to FETCH.
  - IN: go to INPRESS.
  - HALT: go to HALT with no PC strobe.
- MULWAIT: hold until mul_done=1. In that cycle assert wb_en + PC_incr and go to FETCH.
- INPRESS: wait for btn=1, then go to INRELEASE.
- INRELEASE: wait for btn=0. In that cycle assert wb_en + in_sel + PC_incr and go to FETCH.
- HALT: halted=1, all strobes 0. Only reset exits HALT.
- Invariant: at most one of PC_incr/PC_rel_branch/PC_abs_branch is high in any cycle. ir_load is never high with a PC strobe.
- retired_count increments by 1 in every cycle that a PC strobe is asserted. It wraps from 2^RETIRE_WIDTH-1 to 0. HALT does not count.

## Timing
- Reset (async assert, sync release) puts the FSM in FETCH. All outputs are 0 during and after reset, including retired_count.
- Strobes are Moore/Mealy outputs that are combinational from state + opcode/flags and valid within the cycle. The PC updates on the following clk edge.
- Minimum instruction latency is 2 cycles (FETCH, EXEC). MUL takes 2 + N cycles, where N is the number of MULWAIT cycles including the done cycle.
- mul_done outside MULWAIT is ignored. This includes mul_done coinciding with mul_start in EXEC.
- btn already high on entry to INPRESS advances to INRELEASE on the next edge. A btn toggle 1-0 within one cycle is not detected.
- run is sampled only in FETCH. Dropping run mid-instruction completes that instruction and then stalls at the next FETCH.
- An async reset during MULWAIT or INPRESS/INRELEASE aborts immediately: no wb_en, no PC strobe, and the FSM restarts in FETCH.
- illegal is high only in the EXEC cycle.

## Test plan
- Reset, then run=1 with NOP, ADD, JMP → ir_load in cycles 1, 3, 5. PC_incr in cycle 2. wb_en+PC_incr in cycle 4. PC_abs_branch in cycle 6. retired_count=3.
- BEQ with zero_flag=1 then BNE with zero_flag=1 → PC_rel_branch on the first, PC_incr on the second. The three PC strobes are never simultaneously high.
- MUL with mul_done pulsed 5 cycles after mul_start (plus a spurious mul_done during EXEC) → a single mul_start. wb_en+PC_incr occur exactly in the mul_done cycle in MULWAIT, and the spurious pulse is ignored.
- IN with btn held 0 for 3 cycles, 1 for 4 cycles, then 0 → FSM waits. wb_en+in_sel+PC_incr occur only in the first btn=0 cycle after the press.
- Opcode 12 → illegal pulses for 1 cycle and PC_incr is asserted. HALT opcode → halted=1 and stays set for 20 cycles with run=1. Reset clears halted.
- Preset 65535 retirements and retire one more → retired_count=0. Assert reset mid-MULWAIT → outputs go to 0 asynchronously with no wb_en.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Control bundle between the picoMIPS sequencer and the rest of the core.
// master: the sequencer (samples status, drives strobes).
// slave: the datapath side (instruction memory, PC, register file, multiplier).
interface pc_sequencer_if #(
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned RETIRE_WIDTH = 16
);
    // Status into the sequencer
    logic                    run;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    zero_flag;
    logic                    mul_done;
    logic                    btn;

    // Control strobes out of the sequencer
    logic                    ir_load;
    logic                    PC_incr;
    logic                    PC_rel_branch;
    logic                    PC_abs_branch;
    logic                    wb_en;
    logic                    mul_start;
    logic                    in_sel;
    logic                    halted;
    logic                    illegal;
    logic [RETIRE_WIDTH-1:0] retired_count;

    modport master (
        input  run, opcode, zero_flag, mul_done, btn,
        output ir_load, PC_incr, PC_rel_branch, PC_abs_branch, wb_en, mul_start,
               in_sel, halted, illegal, retired_count
    );

    modport slave (
        output run, opcode, zero_flag, mul_done, btn,
        input  ir_load, PC_incr, PC_rel_branch, PC_abs_branch, wb_en, mul_start,
               in_sel, halted, illegal, retired_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM for the picoMIPS core: fetch, decode and drive the PC,
// writeback, multiplier and input-button sequencing. Strobes are combinational
// from the current state and the latched opcode/flags; the PC acts on them at
// the next clock edge.
module pc_sequencer #(
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned RETIRE_WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    localparam logic [OPCODE_WIDTH-1:0] OpNop  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OpAdd  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OpAddi = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OpMul  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OpBeq  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OpBne  = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OpJmp  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OpIn   = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OpHalt = OPCODE_WIDTH'(8);

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StMulWait,
        StInPress,
        StInRelease,
        StHalt
    } state_e;

    state_e                  state_q, state_d;
    logic [OPCODE_WIDTH-1:0] ir_q;
    logic [RETIRE_WIDTH-1:0] retired_q;

    logic ir_load;
    logic pc_incr;
    logic pc_rel;
    logic pc_abs;
    logic wb_en;
    logic mul_start;
    logic in_sel;
    logic illegal;

    // Next-state and strobe decode from the current state and latched opcode
    always_comb begin
        state_d   = state_q;
        ir_load   = 1'b0;
        pc_incr   = 1'b0;
        pc_rel    = 1'b0;
        pc_abs    = 1'b0;
        wb_en     = 1'b0;
        mul_start = 1'b0;
        in_sel    = 1'b0;
        illegal   = 1'b0;

        unique case (state_q)
            StFetch: begin
                // Reset parks the FSM here; keep ir_load quiet while it is held.
                if (bus.run && !reset) begin
                    ir_load = 1'b1;
                    state_d = StExec;
                end
            end

            StExec: begin
                state_d = StFetch;
                case (ir_q)
                    OpNop: pc_incr = 1'b1;
                    OpAdd, OpAddi: begin
                        wb_en   = 1'b1;
                        pc_incr = 1'b1;
                    end
                    OpMul: begin
                        // mul_done in this cycle is deliberately not looked at.
                        mul_start = 1'b1;
                        state_d   = StMulWait;
                    end
                    OpBeq: begin
                        if (bus.zero_flag) pc_rel = 1'b1;
                        else               pc_incr = 1'b1;
                    end
                    OpBne: begin
                        if (bus.zero_flag) pc_incr = 1'b1;
                        else               pc_rel = 1'b1;
                    end
                    OpJmp:  pc_abs  = 1'b1;
                    OpIn:   state_d = StInPress;
                    OpHalt: state_d = StHalt;
                    default: begin
                        // Undefined opcodes behave as NOP but are flagged.
                        illegal = 1'b1;
                        pc_incr = 1'b1;
                    end
                endcase
            end

            StMulWait: begin
                if (bus.mul_done) begin
                    wb_en   = 1'b1;
                    pc_incr = 1'b1;
                    state_d = StFetch;
                end
            end

            StInPress: begin
                if (bus.btn) state_d = StInRelease;
            end

            StInRelease: begin
                // Commit the switch value on the release edge of the button.
                if (!bus.btn) begin
                    wb_en   = 1'b1;
                    in_sel  = 1'b1;
                    pc_incr = 1'b1;
                    state_d = StFetch;
                end
            end

            StHalt: begin
                state_d = StHalt;
            end

            default: state_d = StFetch;
        endcase
    end

    // FSM state and instruction register; IR captures the opcode on fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) ir_q <= bus.opcode;
        end
    end

    // Retired-instruction counter: one count per PC strobe, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (pc_incr || pc_rel || pc_abs) begin
            retired_q <= retired_q + RETIRE_WIDTH'(1);
        end
    end

    assign bus.ir_load       = ir_load;
    assign bus.PC_incr       = pc_incr;
    assign bus.PC_rel_branch = pc_rel;
    assign bus.PC_abs_branch = pc_abs;
    assign bus.wb_en         = wb_en;
    assign bus.mul_start     = mul_start;
    assign bus.in_sel        = in_sel;
    assign bus.illegal       = illegal;
    assign bus.halted        = (state_q == StHalt);
    assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Each instruction task lays down the inputs
// cycle by cycle and queues the outputs that instruction must produce in that
// cycle; a single negedge process checks both DUT instances against the queue.
// A second instance with a 4-bit retire counter exercises the wrap cheaply.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_sequencer_if #(.OPCODE_WIDTH(4), .RETIRE_WIDTH(16)) bus ();
    pc_sequencer_if #(.OPCODE_WIDTH(4), .RETIRE_WIDTH(4))  bus_s ();

    pc_sequencer #(.OPCODE_WIDTH(4), .RETIRE_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pc_sequencer #(.OPCODE_WIDTH(4), .RETIRE_WIDTH(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    assign bus_s.run       = bus.run;
    assign bus_s.opcode    = bus.opcode;
    assign bus_s.zero_flag = bus.zero_flag;
    assign bus_s.mul_done  = bus.mul_done;
    assign bus_s.btn       = bus.btn;

    // Output vector bit masks: {ir_load, incr, rel, abs, wb, mul_start, in_sel, halted, illegal}
    localparam logic [8:0] E_0   = 9'h000;
    localparam logic [8:0] E_IR  = 9'h100;
    localparam logic [8:0] E_INC = 9'h080;
    localparam logic [8:0] E_REL = 9'h040;
    localparam logic [8:0] E_ABS = 9'h020;
    localparam logic [8:0] E_WB  = 9'h010;
    localparam logic [8:0] E_MST = 9'h008;
    localparam logic [8:0] E_INS = 9'h004;
    localparam logic [8:0] E_HLT = 9'h002;
    localparam logic [8:0] E_ILL = 9'h001;

    typedef struct packed {
        logic       rst;
        logic [8:0] o;
    } exp_t;

    exp_t exp_q[$];
    exp_t ent;
    int   exp_ret = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [8:0] act, act_s;
    assign act   = {bus.ir_load, bus.PC_incr, bus.PC_rel_branch, bus.PC_abs_branch, bus.wb_en,
                    bus.mul_start, bus.in_sel, bus.halted, bus.illegal};
    assign act_s = {bus_s.ir_load, bus_s.PC_incr, bus_s.PC_rel_branch, bus_s.PC_abs_branch,
                    bus_s.wb_en, bus_s.mul_start, bus_s.in_sel, bus_s.halted, bus_s.illegal};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // What the EXEC cycle of each opcode must do, straight from the opcode table
    function automatic logic [8:0] exec_exp(input logic [3:0] opc, input bit z);
        case (opc)
            4'd0:       return E_INC;
            4'd1, 4'd2: return E_WB | E_INC;
            4'd3:       return E_MST;
            4'd4:       return z ? E_REL : E_INC;
            4'd5:       return z ? E_INC : E_REL;
            4'd6:       return E_ABS;
            4'd7, 4'd8: return E_0;
            default:    return E_ILL | E_INC;
        endcase
    endfunction

    // One clock of stimulus plus the outputs that must be seen in that clock
    task automatic step(input bit rs, input bit r, input logic [3:0] opc, input bit z,
                        input bit md, input bit b, input logic [8:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        reset         = rs;
        bus.run       = r;
        bus.opcode    = opc;
        bus.zero_flag = z;
        bus.mul_done  = md;
        bus.btn       = b;
        x.rst = rs;
        x.o   = e;
        exp_q.push_back(x);
    endtask

    task automatic fetch(input logic [3:0] opc, input bit z);
        step(1'b0, 1'b1, opc, z, 1'b0, 1'b0, E_IR);
    endtask

    task automatic simple(input logic [3:0] opc, input bit z);
        fetch(opc, z);
        step(1'b0, 1'b1, opc, z, 1'b0, 1'b0, exec_exp(opc, z));
    endtask

    // Compare both instances against the queued expectations every cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            if (ent.rst) exp_ret = 0;
            chk("outputs", {23'd0, act}, {23'd0, ent.o});
            chk("outputs_w4", {23'd0, act_s}, {23'd0, ent.o});
            chk("retired_count", {16'd0, bus.retired_count}, {16'd0, exp_ret[15:0]});
            chk("retired_count_w4", {28'd0, bus_s.retired_count}, {28'd0, exp_ret[3:0]});
            chk("pc_strobe_onehot0",
                {31'd0, $onehot0({bus.PC_incr, bus.PC_rel_branch, bus.PC_abs_branch})}, 32'd1);
            chk("ir_load_exclusive",
                {31'd0, bus.ir_load & (bus.PC_incr | bus.PC_rel_branch | bus.PC_abs_branch)},
                32'd0);
            if (!ent.rst && ((ent.o & (E_INC | E_REL | E_ABS)) != 9'd0)) exp_ret++;
        end
    end

    initial begin
        reset         = 1'b1;
        bus.run       = 1'b1;
        bus.opcode    = 4'd0;
        bus.zero_flag = 1'b0;
        bus.mul_done  = 1'b0;
        bus.btn       = 1'b0;

        // Held in reset with run=1: everything stays low
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, E_0);
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, E_0);
        // run=0 stalls in FETCH
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, E_0);

        // NOP, ADD, JMP
        simple(4'd0, 1'b0);
        simple(4'd1, 1'b0);
        simple(4'd6, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, E_0);
        @(negedge clk);
        chk("lit_retired_after_3", {16'd0, bus.retired_count}, 32'd3);
        chk("lit_model_after_3", exp_ret, 32'd3);

        // Taken BEQ, not-taken BNE
        simple(4'd4, 1'b1);
        simple(4'd5, 1'b1);

        // MUL: spurious done in EXEC, real done 5 cycles after mul_start
        fetch(4'd3, 1'b0);
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, E_MST);
        repeat (4) step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, E_0);
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, E_WB | E_INC);

        // ADD with run dropped during EXEC: completes, then stalls
        fetch(4'd1, 1'b0);
        step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, E_WB | E_INC);
        repeat (2) step(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, E_0);

        // IN: btn 0 x3, 1 x4, then 0
        fetch(4'd7, 1'b0);
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, E_0);
        repeat (3) step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, E_0);
        repeat (4) step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, E_0);
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, E_WB | E_INS | E_INC);

        // IN with btn already high on entry to INPRESS
        fetch(4'd7, 1'b0);
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, E_0);
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, E_0);
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, E_WB | E_INS | E_INC);

        // Illegal opcode, then fill up to 16 retirements
        simple(4'd12, 1'b0);
        simple(4'd2, 1'b0);
        simple(4'd4, 1'b0);
        simple(4'd5, 1'b0);
        simple(4'd0, 1'b0);
        simple(4'd0, 1'b0);
        simple(4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, E_0);
        @(negedge clk);
        chk("lit_retired_16", {16'd0, bus.retired_count}, 32'd16);
        chk("lit_retired_w4_wrap", {28'd0, bus_s.retired_count}, 32'd0);

        // Reset mid-MULWAIT, coinciding with mul_done: no writeback, count cleared
        fetch(4'd3, 1'b0);
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, E_MST);
        repeat (2) step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, E_0);
        step(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, E_0);
        @(negedge clk);
        chk("lit_abort_wb", {31'd0, bus.wb_en}, 32'd0);
        chk("lit_abort_count", {16'd0, bus.retired_count}, 32'd0);
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, E_IR);
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, E_INC);

        // HALT holds for 20 cycles with run=1, then reset releases it
        fetch(4'd8, 1'b0);
        step(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, E_0);
        repeat (20) step(1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 1'b1, E_HLT);
        @(negedge clk);
        chk("lit_halted", {31'd0, bus.halted}, 32'd1);
        chk("lit_halt_count", {16'd0, bus.retired_count}, 32'd1);
        step(1'b1, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, E_0);
        simple(4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, E_0);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
